// File: rtl/cla_pkg.sv
// Shared types and constants for the pipelined carry-lookahead adder.
// GROUP_W : bits handled by one lookahead group / pipeline stage
// MAX_W   : widest operand the stage-register struct can carry
// ngroups : number of groups (and pipeline stages) for a given width
// stage_t : one pipeline stage register
package cla_pkg;

    localparam int unsigned GROUP_W = 4;
    localparam int unsigned MAX_W   = 64;

    function automatic int unsigned ngroups(input int unsigned width);
        return width / GROUP_W;
    endfunction

    // Operands are kept right-aligned and shifted down one group per stage,
    // so every stage always consumes bits [GROUP_W-1:0] of a_rem/b_rem.
    typedef struct packed {
        logic             valid;
        logic [MAX_W-1:0] sum;      // result bits produced so far
        logic [MAX_W-1:0] a_rem;    // A bits not yet consumed
        logic [MAX_W-1:0] b_rem;    // effective B bits not yet consumed
        logic             carry;    // carry out of the last computed group
        logic             msb_cin;  // carry into the top bit of that group
    } stage_t;

endpackage

// File: rtl/cla_pipe_adder_cla4_group.sv
// Purely combinational 4-bit carry-lookahead group.
// a, b : 4-bit operands
// ci   : carry into bit 0
// s    : 4-bit sum
// co   : carry out of bit 3
// c3   : carry into bit 3 (used for signed overflow in the MSB group)
module cla4_group (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);

    logic [3:0] p;
    logic [3:0] g;
    logic       c1;
    logic       c2;

    assign p = a ^ b;
    assign g = a & b;

    // Fully expanded carries: no ripple inside the group.
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
    assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, one 4-bit group per stage.
// Parameter WIDTH : operand width, multiple of 4, 4..64.
// clk, rst        : clock, synchronous active-high reset
// in_valid/ready  : operand handshake (a, b, cin, sub sampled on accept)
// out_valid/ready : result handshake (sum, cout, ovf)
// sub=1 computes a-b as a+~b+1 and ignores cin.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NG = ngroups(WIDTH);

    logic [WIDTH-1:0]   b_eff;
    logic               cin_eff;
    logic [GROUP_W-1:0] grp_a  [NG];
    logic [GROUP_W-1:0] grp_b  [NG];
    logic [GROUP_W-1:0] grp_s  [NG];
    logic               grp_ci [NG];
    logic               grp_co [NG];
    logic               grp_c3 [NG];
    stage_t             st     [NG];
    stage_t             nxt    [NG];
    logic               unused_bits;

    // Subtraction: invert B at acceptance and force the carry-in to 1.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;

    // Whole pipeline advances together; a bubble at the output never stalls.
    assign in_ready = !rst && (!st[NG-1].valid || out_ready);

    // Group operands: stage 0 from the ports, later stages from the previous register.
    always_comb begin
        grp_a[0]  = a[GROUP_W-1:0];
        grp_b[0]  = b_eff[GROUP_W-1:0];
        grp_ci[0] = cin_eff;
        for (int k = 1; k < NG; k++) begin
            grp_a[k]  = st[k-1].a_rem[GROUP_W-1:0];
            grp_b[k]  = st[k-1].b_rem[GROUP_W-1:0];
            grp_ci[k] = st[k-1].carry;
        end
    end

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla4_group u_grp (
            .a  (grp_a[k]),
            .b  (grp_b[k]),
            .ci (grp_ci[k]),
            .s  (grp_s[k]),
            .co (grp_co[k]),
            .c3 (grp_c3[k])
        );
    end

    // Next contents of each stage register.
    always_comb begin
        nxt[0].valid   = in_valid;
        nxt[0].sum     = MAX_W'(grp_s[0]);
        nxt[0].a_rem   = MAX_W'(a) >> GROUP_W;
        nxt[0].b_rem   = MAX_W'(b_eff) >> GROUP_W;
        nxt[0].carry   = grp_co[0];
        nxt[0].msb_cin = grp_c3[0];
        for (int k = 1; k < NG; k++) begin
            nxt[k].valid   = st[k-1].valid;
            nxt[k].sum     = st[k-1].sum;
            nxt[k].sum[k*GROUP_W +: GROUP_W] = grp_s[k];
            nxt[k].a_rem   = st[k-1].a_rem >> GROUP_W;
            nxt[k].b_rem   = st[k-1].b_rem >> GROUP_W;
            nxt[k].carry   = grp_co[k];
            nxt[k].msb_cin = grp_c3[k];
        end
    end

    // Stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NG; k++) begin
                st[k] <= '0;
            end
        end else if (in_ready) begin
            for (int k = 0; k < NG; k++) begin
                st[k] <= nxt[k];
            end
        end
    end

    assign out_valid = st[NG-1].valid;
    assign sum       = st[NG-1].sum[WIDTH-1:0];
    assign cout      = st[NG-1].carry;
    assign ovf       = st[NG-1].carry ^ st[NG-1].msb_cin;

    // Operand leftovers in the final stage have nothing left to feed.
    assign unused_bits = ^{st[NG-1].a_rem, st[NG-1].b_rem, st[NG-1].sum};

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder at WIDTH = 4, 16 and 32.
module tb_cla_pipe_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv = 1'b0;
    int          sel = 16;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        cin_in = 1'b0;
    logic        sub_in = 1'b0;
    logic        out_rdy = 1'b1;

    logic        iv4, iv16, iv32;
    logic        ir4, ir16, ir32;
    logic        ov4, ov16, ov32;
    logic [3:0]  sum4;
    logic [15:0] sum16;
    logic [31:0] sum32;
    logic        co4, co16, co32;
    logic        of4, of16, of32;

    logic        o_rdy, o_val, o_co, o_of;
    logic [31:0] o_sum;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] va   [10] = '{32'h1234, 32'hFFFF, 32'h8000, 32'h0001, 32'h7FFF,
                               32'h00FF, 32'hA5A5, 32'h0000, 32'h4321, 32'hC000};
    logic [31:0] vb   [10] = '{32'h4321, 32'h0001, 32'h8000, 32'h0002, 32'h7FFF,
                               32'hFF01, 32'h5A5A, 32'h0001, 32'h1234, 32'h4000};
    logic        vci  [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        vsub [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    assign iv4  = iv && (sel == 4);
    assign iv16 = iv && (sel == 16);
    assign iv32 = iv && (sel == 32);

    cla_pipe_adder #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
        .a(a_in[3:0]), .b(b_in[3:0]), .cin(cin_in), .sub(sub_in),
        .out_valid(ov4), .out_ready(out_rdy), .sum(sum4), .cout(co4), .ovf(of4)
    );

    cla_pipe_adder #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .a(a_in[15:0]), .b(b_in[15:0]), .cin(cin_in), .sub(sub_in),
        .out_valid(ov16), .out_ready(out_rdy), .sum(sum16), .cout(co16), .ovf(of16)
    );

    cla_pipe_adder #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
        .a(a_in), .b(b_in), .cin(cin_in), .sub(sub_in),
        .out_valid(ov32), .out_ready(out_rdy), .sum(sum32), .cout(co32), .ovf(of32)
    );

    // Outputs of the instance currently under test.
    always_comb begin
        o_rdy = ir16;
        o_val = ov16;
        o_sum = {16'b0, sum16};
        o_co  = co16;
        o_of  = of16;
        case (sel)
            4: begin
                o_rdy = ir4; o_val = ov4; o_sum = {28'b0, sum4}; o_co = co4; o_of = of4;
            end
            32: begin
                o_rdy = ir32; o_val = ov32; o_sum = sum32; o_co = co32; o_of = of32;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide addition, overflow from operand/result sign bits.
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic ci, input logic sb);
        logic [63:0] m, aa, bb, full, s;
        logic co, ov;
        m    = (64'd1 << w) - 64'd1;
        aa   = {32'b0, a} & m;
        bb   = (sb ? ~{32'b0, b} : {32'b0, b}) & m;
        full = aa + bb + 64'(sb ? 1'b1 : ci);
        s    = full & m;
        co   = full[w];
        ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return {ov, co, s[31:0]};
    endfunction

    // One isolated beat: checks latency, result and that it drains.
    task automatic run_one(input int w, input logic [31:0] a, input logic [31:0] b,
                           input logic ci, input logic sb, input logic [31:0] es,
                           input logic ec, input logic eo, input string tag);
        int n;
        sel = w;
        @(negedge clk);
        a_in = a; b_in = b; cin_in = ci; sub_in = sb; iv = 1'b1; out_rdy = 1'b1;
        #1;
        check({tag, "_in_ready"}, 64'(o_rdy), 64'(1));
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0;
        a_in = ~a; b_in = ~b; cin_in = ~ci; sub_in = ~sb;
        n = 0;
        while (!o_val && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(w / 4 - 1));
        check({tag, "_sum"}, 64'(o_sum), 64'(es));
        check({tag, "_cout"}, 64'(o_co), 64'(ec));
        check({tag, "_ovf"}, 64'(o_of), 64'(eo));
        @(negedge clk);
        check({tag, "_drained"}, 64'(o_val), 64'(0));
    endtask

    // Ten beats back-to-back on WIDTH=16, optionally stalling cycles 5..7.
    task automatic stream(input logic stall, input string tag);
        logic [33:0] expq[$];
        logic [33:0] held;
        logic        stall_prev;
        int sent, got, first_c, last_c;
        sent = 0; got = 0; first_c = -1; last_c = -1;
        stall_prev = 1'b0; held = '0;
        sel = 16;
        for (int c = 0; c < 60 && got < 10; c++) begin
            @(negedge clk);
            out_rdy = !(stall && c >= 5 && c <= 7);
            if (sent < 10) begin
                a_in = va[sent]; b_in = vb[sent]; cin_in = vci[sent]; sub_in = vsub[sent];
                iv = 1'b1;
            end else begin
                iv = 1'b0;
            end
            #1;
            if (stall_prev)
                check({tag, "_hold"}, 64'({o_val, o_of, o_co, o_sum}), 64'({1'b1, held}));
            if (stall && c >= 5 && c <= 7)
                check({tag, "_ready_low"}, 64'(o_rdy), 64'(0));
            else
                check({tag, "_ready_high"}, 64'(o_rdy), 64'(1));
            stall_prev = o_val && !out_rdy;
            held = {o_of, o_co, o_sum};
            if (o_val && out_rdy) begin
                if (expq.size() == 0)
                    check({tag, "_extra_beat"}, 64'(1), 64'(0));
                else
                    check({tag, "_result"}, 64'({o_of, o_co, o_sum}), 64'(expq.pop_front()));
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
            end
            if (iv && o_rdy) begin
                expq.push_back(model(16, a_in, b_in, cin_in, sub_in));
                sent++;
            end
        end
        iv = 1'b0;
        out_rdy = 1'b1;
        check({tag, "_count"}, 64'(got), 64'(10));
        check({tag, "_spacing"}, 64'(last_c - first_c), stall ? 64'(12) : 64'(9));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'({ov4, ov16, ov32}), 64'(0));
        check("rst_sum", 64'({sum4, sum16, sum32}), 64'(0));
        check("rst_flags", 64'({co4, co16, co32, of4, of16, of32}), 64'(0));
        check("rst_ready_low", 64'({ir4, ir16, ir32}), 64'(0));
        rst = 1'b0;
        #1;
        check("rst_ready_high", 64'({ir4, ir16, ir32}), 64'(3'b111));

        run_one(16, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0, "w16_add_wrap");
        run_one(16, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1, "w16_add_ovf");
        run_one(16, 32'h0005, 32'h0007, 1'b1, 1'b1, 32'hFFFE, 1'b0, 1'b0, "w16_sub_borrow");
        run_one(16, 32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1, "w16_sub_ovf");

        run_one(4, 32'hF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "w4_add_wrap");
        run_one(4, 32'h7, 32'h1, 1'b0, 1'b0, 32'h8, 1'b0, 1'b1, "w4_add_ovf");
        run_one(4, 32'h5, 32'h7, 1'b1, 1'b1, 32'hE, 1'b0, 1'b0, "w4_sub_borrow");
        run_one(4, 32'h8, 32'h1, 1'b0, 1'b1, 32'h7, 1'b1, 1'b1, "w4_sub_ovf");

        run_one(32, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, "w32_add_wrap");
        run_one(32, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, "w32_add_ovf");
        run_one(32, 32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, "w32_sub_borrow");
        run_one(32, 32'h80000000, 32'h1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, "w32_sub_ovf");

        stream(1'b0, "stream");
        repeat (6) @(negedge clk);
        stream(1'b1, "stall");
        repeat (6) @(negedge clk);

        // Three beats in flight, then a one-cycle reset.
        sel = 16;
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_in = 32'(i + 1); b_in = 32'h1; cin_in = 1'b0; sub_in = 1'b0; iv = 1'b1;
            #1;
            check("flush_accept", 64'(o_rdy), 64'(1));
        end
        @(negedge clk);
        iv = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("flush_valid", 64'(o_val), 64'(0));
        check("flush_outs", 64'({o_sum, o_co, o_of}), 64'(0));
        check("flush_ready_low", 64'(o_rdy), 64'(0));
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_val) cnt++;
        end
        check("flush_no_ghost", 64'(cnt), 64'(0));
        run_one(16, 32'h1234, 32'h1111, 1'b0, 1'b0, 32'h2345, 1'b0, 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
